// File: rtl/blur_pkg.sv
// blur_pkg: shared constants and types for the separable 9x9 binomial blur
package blur_pkg;
   localparam int PIX_W      = 21;
   localparam int TAPS       = 9;
   localparam int NORM_SHIFT = 8;
   localparam int ROUND_BIAS = 128;
   localparam int ACC_W      = 29;
   localparam int KERNEL [TAPS] = '{1, 8, 28, 56, 70, 56, 28, 8, 1};
   typedef logic signed [PIX_W-1:0] pix_t;
   typedef logic [TAPS-1:0][PIX_W-1:0] win_t;
endpackage

// File: rtl/fir9_round.sv
// fir9_round: two-stage 9-tap binomial FIR (registered products, registered rounded sum)
module fir9_round
   import blur_pkg::*;
(
   input  logic clk_in,
   input  logic rst_n_in,
   input  logic en_in,
   input  win_t taps_in,
   output pix_t result_out
);
   logic signed [ACC_W-1:0] r_prod [TAPS];
   logic signed [ACC_W-1:0] w_sum;
   // Products per tap, each sample sign-extended to accumulator width first
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int i = 0; i < TAPS; i++) r_prod[i] <= '0;
      end else begin
         for (int i = 0; i < TAPS; i++)
            r_prod[i] <= {{(ACC_W-PIX_W){taps_in[i][PIX_W-1]}}, taps_in[i]} * ACC_W'(KERNEL[i]);
      end
   end
   // Adder tree seeded with the half-LSB bias so the shift rounds half up
   always_comb begin
      w_sum = ACC_W'(ROUND_BIAS);
      for (int i = 0; i < TAPS; i++) w_sum = w_sum + r_prod[i];
   end
   // Normalise by 256; the result always fits PIX_W, so plain truncation
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) result_out <= '0;
      else if (en_in) result_out <= PIX_W'(w_sum >>> NORM_SHIFT);
   end
endmodule

// File: rtl/separable_blur_9.sv
// separable_blur_9: vertical then horizontal 9-tap binomial smoothing with tag pipeline
module separable_blur_9
   import blur_pkg::*;
(
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  win_t        line_buffer_in,
   input  logic [4:0]  hcount_in,
   input  logic [4:0]  vcount_in,
   input  logic        data_valid_in,
   output pix_t        pixel_out,
   output logic [4:0]  hcount_out,
   output logic [4:0]  vcount_out,
   output logic        data_valid_out
);
   logic [4:0] r_h1, r_v1, r_h2, r_v2, r_h3, r_v3, r_prev_h;
   logic       r_val1, r_val2, r_val3;
   logic [3:0] r_fill, w_fill_nxt;
   logic [TAPS-1:1][PIX_W-1:0] r_win;
   pix_t       w_col;
   win_t       w_hwin;

   // The vertical FIR output register doubles as window entry 0 (newest column)
   fir9_round u_vert (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .en_in(r_val1),
      .taps_in(line_buffer_in), .result_out(w_col)
   );

   assign w_hwin = {r_win, w_col};

   fir9_round u_horz (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .en_in(1'b1),
      .taps_in(w_hwin), .result_out(pixel_out)
   );

   // Fill count: restart on hcount 0 or any gap in hcount, else grow to 9
   always_comb begin
      w_fill_nxt = !r_val1 ? r_fill :
                   (r_h1 != 5'd0 && r_h1 == r_prev_h + 5'd1) ? (r_fill == 4'd9 ? 4'd9 : r_fill + 4'd1) :
                   4'd1;
   end

   // Horizontal window shifts in step with the vertical output, only on valid columns
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_win    <= '0;
         r_fill   <= '0;
         r_prev_h <= '0;
      end else begin
         r_fill <= w_fill_nxt;
         if (r_val1) begin
            r_win    <= {r_win[TAPS-2:1], w_col};
            r_prev_h <= r_h1;
         end
      end
   end

   // Tags follow the data: E1 input, E2 window, E3 horizontal products, E4 output
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         {r_val1, r_val2, r_val3, data_valid_out} <= '0;
         {r_h1, r_h2, r_h3, hcount_out}           <= '0;
         {r_v1, r_v2, r_v3, vcount_out}           <= '0;
      end else begin
         r_val1         <= data_valid_in;
         r_h1           <= hcount_in;
         r_v1           <= vcount_in;
         r_val2         <= r_val1 && w_fill_nxt == 4'd9;
         r_h2           <= r_h1 - 5'd4;
         r_v2           <= r_v1;
         r_val3         <= r_val2;
         r_h3           <= r_h2;
         r_v3           <= r_v2;
         data_valid_out <= r_val3;
         hcount_out     <= r_h3;
         vcount_out     <= r_v3;
      end
   end
endmodule

// File: tb/tb_separable_blur_9.sv
// tb_separable_blur_9: random and directed checks against a column-run reference model
module tb_separable_blur_9;
   logic              clk_in = 1'b0;
   logic              rst_n_in = 1'b0;
   logic [8:0][20:0]  line_buffer_in = '0;
   logic [4:0]        hcount_in = '0;
   logic [4:0]        vcount_in = '0;
   logic              data_valid_in = 1'b0;
   logic signed [20:0] pixel_out;
   logic [4:0]        hcount_out, vcount_out;
   logic              data_valid_out;

   always #5 clk_in = ~clk_in;

   separable_blur_9 dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .line_buffer_in(line_buffer_in),
      .hcount_in(hcount_in), .vcount_in(vcount_in), .data_valid_in(data_valid_in),
      .pixel_out(pixel_out), .hcount_out(hcount_out), .vcount_out(vcount_out),
      .data_valid_out(data_valid_out)
   );

   typedef struct {int due; int pix; logic [4:0] h; logic [4:0] v;} exp_t;
   int K [9] = '{1, 8, 28, 56, 70, 56, 28, 8, 1};
   exp_t q[$];
   int run[$];
   int prev_h = 0, edge_n = 0, n_vec = 0, n_err = 0, n_out = 0;
   logic [20:0] map [32];

   function automatic int kround(input longint s);
      return int'((s + 128) >>> 8);
   endfunction

   task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      assert (got === want) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, $signed(got), $signed(want), edge_n);
      end
   endtask

   task automatic accept();
      longint s;
      if (!data_valid_in) return;
      s = 0;
      for (int i = 0; i < 9; i++) s += K[i] * longint'(signed'(line_buffer_in[i]));
      if (hcount_in == 5'd0 || hcount_in != 5'(prev_h + 1)) run.delete();
      prev_h = int'(hcount_in);
      run.push_back(kround(s));
      if (run.size() > 9) void'(run.pop_front());
      if (run.size() == 9) begin
         s = 0;
         for (int j = 0; j < 9; j++) s += K[j] * longint'(run[j]);
         q.push_back('{edge_n + 3, kround(s), 5'(hcount_in - 5'd4), vcount_in});
      end
   endtask

   task automatic check();
      logic ev;
      exp_t e;
      ev = q.size() > 0 && q[0].due == edge_n;
      cmp("valid", 32'(data_valid_out), 32'(ev));
      if (data_valid_out) begin
         n_out++;
         map[hcount_out] = pixel_out;
      end
      if (ev) begin
         e = q.pop_front();
         cmp("pixel", 32'(pixel_out), 32'(e.pix));
         cmp("hcount", 32'(hcount_out), 32'(e.h));
         cmp("vcount", 32'(vcount_out), 32'(e.v));
      end
   endtask

   task automatic tick(input logic val, input int h, input int v);
      data_valid_in = val;
      hcount_in = 5'(h);
      vcount_in = 5'(v);
      @(posedge clk_in);
      edge_n++;
      if (rst_n_in) accept();
      @(negedge clk_in);
      check();
   endtask

   task automatic flush(input int n);
      repeat (n) tick(1'b0, 0, 0);
   endtask

   task automatic rand_rows();
      for (int i = 0; i < 9; i++) line_buffer_in[i] = 21'($urandom);
   endtask

   task automatic fill_const(input int val);
      for (int i = 0; i < 9; i++) line_buffer_in[i] = 21'(val);
   endtask

   task automatic row(input logic rnd, input int v, input int h0, input int h1);
      for (int h = h0; h <= h1; h++) begin
         if (rnd) rand_rows();
         tick(1'b1, h, v);
      end
   endtask

   task automatic clear_map();
      for (int i = 0; i < 32; i++) map[i] = 'x;
   endtask

   task automatic zero_outputs(input string tag);
      cmp({tag, "_pix"}, 32'(pixel_out), 0);
      cmp({tag, "_h"}, 32'(hcount_out), 0);
      cmp({tag, "_v"}, 32'(vcount_out), 0);
      cmp({tag, "_valid"}, 32'(data_valid_out), 0);
   endtask

   task automatic do_reset();
      #2 rst_n_in = 1'b0;
      q.delete();
      run.delete();
      prev_h = 0;
      #1 zero_outputs("rst_mid");
      flush(2);
      rst_n_in = 1'b1;
   endtask

   int fs_vals [3] = '{-3, 1048575, -1048576};

   initial begin
      repeat (2) @(negedge clk_in);
      zero_outputs("rst_init");
      rst_n_in = 1'b1;

      n_out = 0; clear_map(); fill_const(1000);
      row(1'b0, 5, 0, 23); flush(4);
      cmp("const1000_count", 32'(n_out), 16);
      cmp("const1000_c4", 32'(map[4]), 1000);
      cmp("const1000_c19", 32'(map[19]), 1000);

      n_out = 0; clear_map();
      for (int h = 0; h < 24; h++) begin
         line_buffer_in = '0;
         if (h == 10) line_buffer_in[4] = 21'd256;
         tick(1'b1, h, 6);
      end
      flush(4);
      cmp("imp_c10", 32'(map[10]), 19);
      cmp("imp_c9", 32'(map[9]), 15);
      cmp("imp_c11", 32'(map[11]), 15);
      cmp("imp_c6", 32'(map[6]), 0);
      cmp("imp_c14", 32'(map[14]), 0);

      foreach (fs_vals[k]) begin
         n_out = 0; clear_map(); fill_const(fs_vals[k]);
         row(1'b0, 7, 0, 23); flush(4);
         cmp("flat_count", 32'(n_out), 16);
         cmp("flat_c12", 32'(signed'(map[12])), 32'(fs_vals[k]));
      end

      n_out = 0;
      row(1'b1, 8, 0, 12); flush(5); row(1'b1, 8, 13, 23); flush(4);
      cmp("gap_count", 32'(n_out), 16);

      row(1'b1, 9, 0, 12); flush(4);
      n_out = 0; clear_map();
      row(1'b1, 9, 15, 23); flush(4);
      cmp("jump_count", 32'(n_out), 1);
      cmp("jump_c19_seen", 32'(map[19] !== 21'bx), 1);

      row(1'b1, 10, 0, 15);
      do_reset();
      n_out = 0;
      row(1'b1, 10, 16, 23); flush(4);
      cmp("post_rst_count", 32'(n_out), 0);
      n_out = 0;
      row(1'b1, 11, 0, 23); flush(4);
      cmp("post_rst_row", 32'(n_out), 16);

      n_out = 0;
      row(1'b1, 1, 0, 23); row(1'b1, 2, 0, 23); flush(4);
      cmp("b2b_count", 32'(n_out), 32);

      for (int r = 0; r < 6; r++) begin
         int h;
         h = 0;
         while (h < 24) begin
            if ($urandom_range(3) == 0) tick(1'b0, 0, 0);
            else begin
               rand_rows();
               tick(1'b1, h, r + 12);
               h += ($urandom_range(15) == 0) ? 2 : 1;
            end
         end
      end
      flush(4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/separable_blur_9.md
# separable_blur_9

Separable 9×9 binomial smoothing stage. It consumes the nine-row column window produced by the rolling line buffer: nine vertically adjacent 21-bit signed pixels per cycle, plus hcount, vcount and valid. It applies a 9-tap vertical kernel, shifts the resulting column values through a 9-deep horizontal window, and applies the same 9-tap kernel horizontally. It emits one smoothed 21-bit signed pixel per valid column, centred on the window, and feeds the difference/keypoint stages downstream.

## Interface
- PIX_W, 21, pixel width (signed)
- TAPS, 9, kernel length (fixed; the package constant must agree)
- clk_in  input  1  system clock
- rst_n_in  input  1  reset, asynchronous, active-low
- line_buffer_in  input  [8:0][20:0] signed  column window; [8] top row, [0] bottom row
- hcount_in  input  5  column of the incoming window
- vcount_in  input  5  centre row of the incoming window (already adjusted upstream)
- data_valid_in  input  1  window valid this cycle
- pixel_out  output  21 signed  smoothed pixel
- hcount_out  output  5  column of pixel_out (window centre)
- vcount_out  output  5  row of pixel_out
- data_valid_out  output  1  pixel_out valid this cycle

## Operation
- Kernel K = {1,8,28,56,70,56,28,8,1}, sum 256; normalise by add 128 then arithmetic shift right 8 (round half up).
- Vertical stage: col = round(Σ K[i]·line_buffer_in[i]). Accumulate in 29-bit signed; |x| ≤ 2^20·256 = 2^28. Truncate the result to 21 bits; it provably fits, so no saturation logic.
- Horizontal window: 9-entry shift register of col values. It shifts only on a valid column; invalid cycles hold all contents.
- Fill counter fill (0..9, saturating):
  - Valid with hcount == 0: fill ← 1 (row restart; stale entries are ignored).
  - Valid with hcount == previous valid hcount + 1: fill ← min(fill+1, 9).
  - Any other valid hcount (discontinuity): fill ← 1.
- Horizontal stage: pix = round(Σ K[j]·window[j]), same widths and rounding.
- Output valid only when the window was full (fill == 9 after the shift). It carries hcount = the newest column's hcount − 4 and that sample's vcount.
- Per row, only columns 4..(last−4) are produced; border columns are never emitted.
- No vertical gating: vcount passes through untouched.
- Reset (async assert, sync release): pixel_out=0, hcount_out=0, vcount_out=0, data_valid_out=0, fill=0, window=0, all pipeline valid tags 0. A reset mid-row discards partial windows; the first output after release requires 9 fresh consecutive columns.

## Timing
- 4 register stages, no backpressure, throughput 1 column per cycle.
  - E1: vertical products plus tags.
  - E2: column rounding, window shift and fill update.
  - E3: horizontal products.
  - E4: output register.
- Sample accepted at edge k → corresponding output visible after edge k+3.
- Tags (hcount, vcount, valid) travel alongside the data in every stage; invalid bubbles propagate as data_valid_out=0.
- Back-to-back valids at hcount 0..23 give data_valid_out high for exactly 16 consecutive cycles (hcount_out 4..19).
- Row restart and window shift in the same cycle: the restart wins. The new column is entry 0 and fill = 1.

## Structure
- Package blur_pkg: PIX_W, TAPS, KERNEL array, NORM_SHIFT=8, ROUND_BIAS=128, ACC_W=29.
- Sub-module fir9_round: registered 9 products, then a registered adder tree with round/shift. It is instantiated twice (vertical, horizontal), and each instance supplies two of the four stages.
- The top level holds the window shift register, fill counter and tag pipeline.

## Test plan
- Constant 1000 on all rows, hcount 0..23 contiguous → 16 outputs of 1000, hcount_out 4..19, first output 3 edges after the 9th input.
- Impulse 256 at row [4], column 10, zeros elsewhere → output 19 at hcount_out 10. Neighbours: column 9/11 → round(70·56/256 … )=round(56·… ) = 15, column 6/14 → 0.
- Constant −3 → all outputs −3; full-scale +(2^20−1) → 2^20−1 and full-scale −2^20 → −2^20, with no wrap.
- Valid deasserted for 5 cycles at hcount 12, then resumed at 13 → output stream holds and resumes with correct values and no extra outputs. A jump from 12 to 15 → no outputs until hcount 23, then hcount_out 19 only.
- rst_n_in pulsed low mid-row at hcount 15 → outputs 0 immediately; no valid until 9 new contiguous columns arrive.
- Two rows back-to-back (hcount 23 → 0 without a gap) → the first outputs of row 2 use no row-1 columns; row 2 yields exactly 16 outputs.
